min_scan_ctrl: RTL and testbench
================================

MIN_SCAN_CTRL -- requirements
Module: min_scan_ctrl

Interface
REQ-001 SHALL have parameter MAX_CAND, default 15, meaning the maximum number of candidates per scan (1..15).
REQ-002 SHALL have parameter BLOCKED_ENE, default 8'hFF, meaning the energy code that marks a blocked (wall) candidate.
REQ-003 SHALL have port p_reset  in  1  reset: asynchronous, active-low.
REQ-004 SHALL have port m_clock  in  1  clock: all state changes on its rising edge.
REQ-005 SHALL have port start  in  1  single-cycle pulse that opens a scan; ignored unless in IDLE.
REQ-006 SHALL have port abort  in  1  cancels the scan in any state.
REQ-007 SHALL have port cand_valid  in  1  candidate present.
REQ-008 SHALL have port cand_ready  out  1  candidate accepted this cycle when cand_valid is also high.
REQ-009 SHALL have port cand_ene  in  8  candidate energy, unsigned.
REQ-010 SHALL have port cand_dir  in  8  candidate direction code (ud/lr), opaque.
REQ-011 SHALL have port cand_last  in  1  marks the final candidate of the scan.
REQ-012 SHALL have port res_valid  out  1  result available.
REQ-013 SHALL have port res_ready  in  1  result consumed when res_valid is also high.
REQ-014 SHALL have port res_ene, res_dir  out  8 each  minimum energy and its direction.
REQ-015 SHALL have port res_count  out  4  number of candidates accepted in the scan.
REQ-016 SHALL have port res_none, res_ovf  out  1 each  all candidates blocked; scan truncated at MAX_CAND.
REQ-017 SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-018 SHALL implement the states IDLE, COLLECT and RESULT.
REQ-019 SHALL go from IDLE to COLLECT on start, clearing count, best_ene=8'hFF, best_dir=0, any_valid=0 and ovf=0.
REQ-020 SHALL drive cand_ready high only in COLLECT (combinational from state).
REQ-021 SHALL, on acceptance of a candidate, update the registered best on the same edge, giving a 1-cycle latency.
REQ-022 SHALL compare through one min_select instance with inene1=cand_ene, inene2=best_ene, ud_lr1=cand_dir, ud_lr2=best_dir and min_select_exe=1.
REQ-023 SHALL use strict less-than, so that on equal energy the earlier candidate is kept.
REQ-024 SHALL skip a candidate with cand_ene==BLOCKED_ENE for comparison while still counting it.
REQ-025 SHALL treat the first non-blocked candidate as the new best unconditionally and set any_valid.
REQ-026 SHALL go from COLLECT to RESULT on an accepted candidate carrying cand_last, with res_valid asserted the next cycle.
REQ-027 SHALL, when count reaches MAX_CAND without cand_last, set ovf, go to RESULT and deassert cand_ready from the next cycle.
REQ-028 SHALL, in RESULT, hold res_valid and all res_* outputs stable until res_ready, then return to IDLE on the next edge.
REQ-029 SHALL set res_none = ~any_valid; when res_none=1, res_ene SHALL be 8'hFF and res_dir SHALL be 0.
REQ-030 SHALL, on abort, go to IDLE on the next edge from any state with no result issued, abort taking priority over cand_last and res_ready.
REQ-031 SHALL ignore start while busy.
REQ-032 SHALL support back-to-back scans: start in the IDLE cycle immediately after a result is consumed is accepted.

Reset
REQ-033 SHALL, while p_reset=0, force state=IDLE, cand_ready=0, res_valid=0, busy=0, res_ene=8'hFF, res_dir=0, res_count=0, res_none=0 and res_ovf=0.
REQ-034 SHALL, on reset mid-scan, drop partial results silently.

Structure
REQ-035 SHALL place the state encoding, BLOCKED_ENE default and MAX_CAND default in the shared search package.
REQ-036 SHALL instantiate exactly one sub-module, the existing min_select comparator, and contain no other arithmetic beside the 4-bit counter.

Verification
REQ-037 SHALL verify that energies 30,12,40 (dirs 1,2,3, last on 3rd) produce res_ene=12, res_dir=2, res_count=3, res_none=0.
REQ-038 SHALL verify that energies 7,7 (dirs 5,9) produce res_dir=5, showing the tie keeps the earlier candidate.
REQ-039 SHALL verify that energies FF,FF,FF produce res_none=1, res_ene=FF, res_dir=0, res_count=3.
REQ-040 SHALL verify that 15 candidates without last, the 9th energy 3, produce res_ovf=1, res_count=15, res_ene=3 and cand_ready=0 afterwards.
REQ-041 SHALL verify that abort after 2 candidates gives IDLE next cycle with no res_valid, and that a following scan gives a correct result.
REQ-042 SHALL verify that res_ready held low for 5 cycles keeps outputs stable, and that p_reset asserted in COLLECT brings all outputs to their reset values.

Source files
------------

// File: rtl/min_scan_ctrl_pkg.sv
// Shared search package: scan FSM encoding, default scan limits and
// the blocked-candidate test used by the minimum-energy scanner.
package min_scan_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_RESULT  = 2'd2
   } scan_state_e;

   localparam int unsigned MAX_CAND_DEF    = 15;
   localparam logic [7:0]  BLOCKED_ENE_DEF = 8'hFF;
   localparam logic [7:0]  ENE_INIT        = 8'hFF;
   localparam logic [7:0]  DIR_INIT        = 8'h00;

   function automatic logic is_blocked(input logic [7:0] ene, input logic [7:0] blocked_code);
      return (ene == blocked_code);
   endfunction

endpackage

// File: rtl/min_scan_ctrl_if.sv
// Candidate / result handshake bundle between a scan client (master)
// and the minimum-energy scan controller (slave).
interface min_scan_ctrl_if;

   logic       start;
   logic       abort;
   logic       cand_valid;
   logic       cand_ready;
   logic [7:0] cand_ene;
   logic [7:0] cand_dir;
   logic       cand_last;
   logic       res_valid;
   logic       res_ready;
   logic [7:0] res_ene;
   logic [7:0] res_dir;
   logic [3:0] res_count;
   logic       res_none;
   logic       res_ovf;
   logic       busy;

   modport master (
      output start, abort, cand_valid, cand_ene, cand_dir, cand_last, res_ready,
      input  cand_ready, res_valid, res_ene, res_dir, res_count, res_none, res_ovf, busy
   );

   modport slave (
      input  start, abort, cand_valid, cand_ene, cand_dir, cand_last, res_ready,
      output cand_ready, res_valid, res_ene, res_dir, res_count, res_none, res_ovf, busy
   );

endinterface

// File: rtl/min_scan_ctrl_min_select.sv
// Two-way minimum comparator: passes the lower-energy input and its direction.
// Strict less-than, so input 2 (the incumbent) wins ties.
module min_select (
   input  logic [7:0] inene1,
   input  logic [7:0] inene2,
   input  logic [7:0] ud_lr1,
   input  logic [7:0] ud_lr2,
   input  logic       min_select_exe,
   output logic [7:0] outene,
   output logic [7:0] out_ud_lr
);

   // Select the smaller energy when enabled, otherwise keep input 2
   always_comb begin
      outene    = inene2;
      out_ud_lr = ud_lr2;
      if (min_select_exe && (inene1 < inene2)) begin
         outene    = inene1;
         out_ud_lr = ud_lr1;
      end else begin
         outene    = inene2;
         out_ud_lr = ud_lr2;
      end
   end

endmodule

// File: rtl/min_scan_ctrl.sv
// Minimum-energy scan controller: collects up to MAX_CAND candidates,
// tracks the lowest non-blocked energy and presents it as a held result.
module min_scan_ctrl
   import min_scan_ctrl_pkg::*;
#(
   parameter int unsigned MAX_CAND    = MAX_CAND_DEF,
   parameter logic [7:0]  BLOCKED_ENE = BLOCKED_ENE_DEF
) (
   input  logic             m_clock,
   input  logic             p_reset,
   min_scan_ctrl_if.slave   bus
);

   localparam logic [3:0] MAX_CNT = 4'(MAX_CAND);

   scan_state_e state_q, state_d;
   logic [3:0]  count_q, count_d;
   logic [7:0]  best_ene_q, best_ene_d;
   logic [7:0]  best_dir_q, best_dir_d;
   logic        any_valid_q, any_valid_d;
   logic        ovf_q, ovf_d;

   logic [7:0]  sel_ene_s;
   logic [7:0]  sel_dir_s;
   logic [3:0]  count_inc_s;
   logic        blocked_s;

   min_select u_min_select (
      .inene1         (bus.cand_ene),
      .inene2         (best_ene_q),
      .ud_lr1         (bus.cand_dir),
      .ud_lr2         (best_dir_q),
      .min_select_exe (1'b1),
      .outene         (sel_ene_s),
      .out_ud_lr      (sel_dir_s)
   );

   assign count_inc_s = count_q + 4'd1;
   assign blocked_s   = is_blocked(bus.cand_ene, BLOCKED_ENE);

   // State and scan-accumulator registers
   always_ff @(posedge m_clock or negedge p_reset) begin
      if (!p_reset) begin
         state_q     <= ST_IDLE;
         count_q     <= 4'd0;
         best_ene_q  <= ENE_INIT;
         best_dir_q  <= DIR_INIT;
         any_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         best_ene_q  <= best_ene_d;
         best_dir_q  <= best_dir_d;
         any_valid_q <= any_valid_d;
         ovf_q       <= ovf_d;
      end
   end

   // Next-state and accumulator update; abort overrides every other event
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      best_ene_d  = best_ene_q;
      best_dir_d  = best_dir_q;
      any_valid_d = any_valid_q;
      ovf_d       = ovf_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start && !bus.abort) begin
               state_d     = ST_COLLECT;
               count_d     = 4'd0;
               best_ene_d  = ENE_INIT;
               best_dir_d  = DIR_INIT;
               any_valid_d = 1'b0;
               ovf_d       = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_COLLECT: begin
            if (bus.abort) begin
               state_d = ST_IDLE;
            end else if (bus.cand_valid) begin
               count_d = count_inc_s;
               if (blocked_s) begin
                  best_ene_d = best_ene_q;
               end else if (!any_valid_q) begin
                  // First usable candidate seeds the minimum regardless of its value
                  best_ene_d  = bus.cand_ene;
                  best_dir_d  = bus.cand_dir;
                  any_valid_d = 1'b1;
               end else begin
                  best_ene_d = sel_ene_s;
                  best_dir_d = sel_dir_s;
               end
               if (bus.cand_last) begin
                  state_d = ST_RESULT;
               end else if (count_inc_s == MAX_CNT) begin
                  state_d = ST_RESULT;
                  ovf_d   = 1'b1;
               end else begin
                  state_d = ST_COLLECT;
               end
            end else begin
               state_d = ST_COLLECT;
            end
         end
         ST_RESULT: begin
            if (bus.abort || bus.res_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RESULT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.cand_ready = (state_q == ST_COLLECT);
   assign bus.res_valid  = (state_q == ST_RESULT);
   assign bus.busy       = (state_q != ST_IDLE);
   assign bus.res_ene    = best_ene_q;
   assign bus.res_dir    = best_dir_q;
   assign bus.res_count  = count_q;
   assign bus.res_ovf    = ovf_q;
   assign bus.res_none   = (state_q == ST_RESULT) && !any_valid_q;

endmodule

// File: tb/tb_min_scan_ctrl.sv
// Randomised scoreboard bench for min_scan_ctrl: a list-based reference model
// predicts each scan result and a negedge monitor compares what the DUT presents.
module tb_min_scan_ctrl;

   logic m_clock = 1'b0;
   logic p_reset = 1'b0;

   min_scan_ctrl_if bus ();

   min_scan_ctrl dut (
      .m_clock (m_clock),
      .p_reset (p_reset),
      .bus     (bus)
   );

   always #5 m_clock = ~m_clock;

   typedef struct {
      logic [7:0] ene;
      logic [7:0] dir;
      logic [3:0] count;
      logic       none;
      logic       ovf;
   } exp_t;

   exp_t       exp_q[$];
   int         vectors     = 0;
   int         miscompares = 0;
   logic [7:0] ene_a [16];
   logic [7:0] dir_a [16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Reference: minimum over the candidate list, blocked codes ignored, first wins ties
   function automatic exp_t model(input int n, input bit has_last);
      exp_t e;
      bit   found = 1'b0;
      e.ene   = 8'hFF;
      e.dir   = 8'h00;
      for (int i = 0; i < n; i++) begin
         if (ene_a[i] != 8'hFF) begin
            if (!found || ene_a[i] < e.ene) begin
               e.ene = ene_a[i];
               e.dir = dir_a[i];
            end
            found = 1'b1;
         end
      end
      e.count = 4'(n);
      e.none  = !found;
      e.ovf   = !has_last && (n == 15);
      return e;
   endfunction

   // Monitor: every presented result must match the oldest outstanding prediction
   initial begin
      forever begin
         @(negedge m_clock);
         if (p_reset && bus.res_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_res_valid", 32'(bus.res_valid), 32'd0);
            end else begin
               check("res_ene",   32'(bus.res_ene),   32'(exp_q[0].ene));
               check("res_dir",   32'(bus.res_dir),   32'(exp_q[0].dir));
               check("res_count", 32'(bus.res_count), 32'(exp_q[0].count));
               check("res_none",  32'(bus.res_none),  32'(exp_q[0].none));
               check("res_ovf",   32'(bus.res_ovf),   32'(exp_q[0].ovf));
               if (bus.res_ready) begin
                  void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge m_clock);
      #1;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_cand_ready"}, 32'(bus.cand_ready), 32'd0);
      check({tag, "_res_valid"},  32'(bus.res_valid),  32'd0);
      check({tag, "_busy"},       32'(bus.busy),       32'd0);
      check({tag, "_res_ene"},    32'(bus.res_ene),    32'hFF);
      check({tag, "_res_dir"},    32'(bus.res_dir),    32'd0);
      check({tag, "_res_count"},  32'(bus.res_count),  32'd0);
      check({tag, "_res_none"},   32'(bus.res_none),   32'd0);
      check({tag, "_res_ovf"},    32'(bus.res_ovf),    32'd0);
   endtask

   task automatic start_scan();
      int k = 0;
      while (bus.busy && k < 50) begin
         tick();
         k++;
      end
      if (bus.busy) begin
         check("wait_idle_timeout", 32'(bus.busy), 32'd0);
      end
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic send(input int i, input bit last);
      bit ok = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
         tick();
      end
      bus.cand_valid = 1'b1;
      bus.cand_ene   = ene_a[i];
      bus.cand_dir   = dir_a[i];
      bus.cand_last  = last;
      for (int k = 0; k < 20; k++) begin
         @(negedge m_clock);
         ok = bus.cand_ready;
         tick();
         if (ok) break;
      end
      if (!ok) begin
         check("cand_accept_timeout", 32'(ok), 32'd1);
      end
      bus.cand_valid = 1'b0;
      bus.cand_last  = 1'b0;
   endtask

   task automatic consume(input int hold);
      bit seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge m_clock);
         if (bus.res_valid) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         check("res_valid_timeout", 32'(seen), 32'd1);
      end else begin
         tick();
         for (int k = 0; k < hold; k++) begin
            tick();
         end
         bus.res_ready = 1'b1;
         tick();
         bus.res_ready = 1'b0;
      end
   endtask

   task automatic run_scan(input int n, input bit has_last, input int hold);
      exp_q.push_back(model(n, has_last));
      start_scan();
      for (int i = 0; i < n; i++) begin
         send(i, has_last && (i == n - 1));
      end
      consume(hold);
   endtask

   task automatic fill_random(input int n);
      for (int i = 0; i < n; i++) begin
         ene_a[i] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 31));
         dir_a[i] = 8'($urandom);
      end
   endtask

   initial begin
      int n;
      bit hl;
      bus.start      = 1'b0;
      bus.abort      = 1'b0;
      bus.cand_valid = 1'b0;
      bus.cand_ene   = 8'h00;
      bus.cand_dir   = 8'h00;
      bus.cand_last  = 1'b0;
      bus.res_ready  = 1'b0;

      #12;
      check_reset_vals("por");
      tick();
      p_reset = 1'b1;
      tick();

      // Basic minimum
      ene_a[0] = 8'd30; ene_a[1] = 8'd12; ene_a[2] = 8'd40;
      dir_a[0] = 8'd1;  dir_a[1] = 8'd2;  dir_a[2] = 8'd3;
      run_scan(3, 1'b1, 0);

      // Tie keeps the earlier candidate
      ene_a[0] = 8'd7; ene_a[1] = 8'd7;
      dir_a[0] = 8'd5; dir_a[1] = 8'd9;
      run_scan(2, 1'b1, 1);

      // All blocked
      for (int i = 0; i < 3; i++) begin
         ene_a[i] = 8'hFF;
         dir_a[i] = 8'(i + 1);
      end
      run_scan(3, 1'b1, 0);

      // Truncation at 15 without last, minimum 3 at the 9th
      for (int i = 0; i < 15; i++) begin
         ene_a[i] = ($urandom_range(0, 4) == 0) ? 8'hFF : 8'($urandom_range(4, 254));
         dir_a[i] = 8'($urandom);
      end
      ene_a[8] = 8'd3;
      exp_q.push_back(model(15, 1'b0));
      start_scan();
      for (int i = 0; i < 15; i++) begin
         send(i, 1'b0);
      end
      check("ovf_cand_ready_low", 32'(bus.cand_ready), 32'd0);
      bus.cand_valid = 1'b1;
      bus.cand_ene   = 8'd0;
      tick();
      bus.cand_valid = 1'b0;
      check("ovf_cand_ready_low2", 32'(bus.cand_ready), 32'd0);
      consume(0);

      // Abort after two candidates, then a clean scan
      fill_random(2);
      start_scan();
      send(0, 1'b0);
      send(1, 1'b0);
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_res_valid", 32'(bus.res_valid), 32'd0);
      tick();
      tick();
      ene_a[0] = 8'd30; ene_a[1] = 8'd12; ene_a[2] = 8'd40;
      dir_a[0] = 8'd1;  dir_a[1] = 8'd2;  dir_a[2] = 8'd3;
      run_scan(3, 1'b1, 0);

      // Result held five cycles before consumption
      fill_random(6);
      run_scan(6, 1'b1, 5);

      // Reset asserted in COLLECT drops the partial scan
      fill_random(3);
      start_scan();
      send(0, 1'b0);
      send(1, 1'b0);
      p_reset = 1'b0;
      #1;
      check_reset_vals("mid");
      tick();
      p_reset = 1'b1;
      tick();
      fill_random(4);
      run_scan(4, 1'b1, 0);

      // Randomised back-to-back scans
      for (int s = 0; s < 30; s++) begin
         n  = $urandom_range(1, 15);
         hl = (n < 15) ? 1'b1 : 1'($urandom_range(0, 1));
         fill_random(n);
         run_scan(n, hl, $urandom_range(0, 3));
      end

      tick();
      tick();
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
